// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised UART transceiver.
//   - Fractional baud generator producing a 16x oversample tick.
//   - TX FSM with ready/valid byte input, LSB-first framing.
//   - RX FSM with 2-flop synchroniser, centre sampling and an RX FIFO
//     carrying per-byte frame/parity error flags.
// Compile-time option: define UART_PARITY_EN to add a parity bit to every
// frame (PARITY_ODD selects the sense). Without it the frame carries no
// parity bit and rx_parity_err_o is tied low.
module uart_xcvr #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic                               tx,
    input  logic [11:0]                        baud_freq_i,
    input  logic [15:0]                        baud_limit_i,
    input  logic [DATA_BITS-1:0]               tx_data_i,
    input  logic                               tx_valid_i,
    output logic                               tx_ready_o,
    output logic [DATA_BITS-1:0]               rx_data_o,
    output logic                               rx_frame_err_o,
    output logic                               rx_parity_err_o,
    output logic                               rx_valid_o,
    input  logic                               rx_ready_i,
    output logic                               rx_overrun_o,
    output logic [$clog2(RX_FIFO_DEPTH):0]     rx_count_o
);

    localparam int   AW      = $clog2(RX_FIFO_DEPTH);
    localparam logic PAR_ODD = (PARITY_ODD != 0);
`ifdef UART_PARITY_EN
    localparam int   EW      = DATA_BITS + 2;
`else
    localparam int   EW      = DATA_BITS + 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [15:0] acc;
    logic [16:0] sum;
    logic        tick;

    // Accumulator sum and tick decision; a limit of zero ticks every cycle.
    always_comb begin
        sum  = {1'b0, acc} + {5'b0, baud_freq_i};
        tick = (sum >= {1'b0, baud_limit_i});
    end

    // Accumulator register: subtract the modulus whenever a tick is issued.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      acc <= '0;
        else if (tick) acc <= sum[15:0] - baud_limit_i;
        else           acc <= sum[15:0];
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               tx_state, tx_next;
    logic [3:0]           tx_sub, tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_bit_end;
    logic                 tx_accept;

    assign tx_bit_end = tick && (tx_sub == 4'hF);
    assign tx_ready_o = (tx_state == S_IDLE);
    assign tx_accept  = tx_valid_i && tx_ready_o;

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= S_IDLE;
        else      tx_state <= tx_next;
    end

    // TX next-state and serial output.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tx_next = tx_state;
        tx      = 1'b1;
        case (tx_state)
            S_IDLE:   if (tx_accept) tx_next = S_START;
            S_START: begin
                tx = 1'b0;
                if (tx_bit_end) tx_next = S_DATA;
            end
            S_DATA: begin
                tx = tx_shift[0];
                if (tx_bit_end && tx_bit == 4'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
                    tx_next = S_PARITY;
`else
                    tx_next = S_STOP;
`endif
            end
            S_PARITY: begin
                tx = tx_par;
                if (tx_bit_end) tx_next = S_STOP;
            end
            S_STOP:   if (tx_bit_end && tx_bit == 4'(STOP_BITS - 1)) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    // TX datapath: byte capture, shifting, tick sub-counter and bit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_sub   <= '0;
            tx_bit   <= '0;
        end else begin
            if (tx_accept) begin
                tx_shift <= tx_data_i;
                tx_par   <= (^tx_data_i) ^ PAR_ODD;
            end else if (tx_state == S_DATA && tx_bit_end) begin
                tx_shift <= tx_shift >> 1;
            end
            if (tx_state == S_IDLE) tx_sub <= '0;
            else if (tick)          tx_sub <= tx_sub + 4'd1;
            if (tx_next != tx_state) tx_bit <= '0;
            else if (tx_bit_end)     tx_bit <= tx_bit + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           rx_sync;
    logic                 rx_s;
    state_t               rx_state, rx_next;
    logic [3:0]           rx_sub, rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_armed;
    logic                 rx_sample;
    logic                 rx_push;
    logic [EW-1:0]        rx_entry;

    assign rx_s      = rx_sync[1];
    assign rx_sample = tick && (rx_sub == 4'hF);

    // Two-flop synchroniser, preset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_sync <= 2'b11;
        else      rx_sync <= {rx_sync[0], rx};
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= S_IDLE;
        else      rx_state <= rx_next;
    end

    // RX next-state; the stop-bit sample pushes the frame into the FIFO.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        case (rx_state)
            S_IDLE:   if (!rx_s && rx_armed) rx_next = S_START;
            S_START:  if (tick && rx_sub == 4'd7) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_sample && rx_bit == 4'(DATA_BITS - 1))
`ifdef UART_PARITY_EN
                    rx_next = S_PARITY;
`else
                    rx_next = S_STOP;
`endif
            S_PARITY: if (rx_sample) rx_next = S_STOP;
            S_STOP: begin
                if (rx_sample) begin
                    rx_push = 1'b1;
                    rx_next = S_IDLE;
                end
            end
            default:  rx_next = S_IDLE;
        endcase
    end

    // RX datapath: sub-counter, bit index, shift register and re-arm flag.
    // After a low stop bit the line must go high again before a new start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b1;
        end else begin
            if (rx_next != rx_state || rx_state == S_IDLE) rx_sub <= '0;
            else if (tick)                                  rx_sub <= rx_sub + 4'd1;
            if (rx_next != rx_state)                   rx_bit <= '0;
            else if (rx_state == S_DATA && rx_sample)  rx_bit <= rx_bit + 4'd1;
            if (rx_state == S_DATA && rx_sample)
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_s)         rx_armed <= 1'b1;
            else if (rx_push) rx_armed <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    logic rx_perr;

    // Parity check: mismatch between the received bit and the recomputed one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     rx_perr <= 1'b0;
        else if (rx_state == S_START)                 rx_perr <= 1'b0;
        else if (rx_state == S_PARITY && rx_sample)   rx_perr <= rx_s ^ (^rx_shift) ^ PAR_ODD;
    end

    assign rx_entry = {rx_perr, ~rx_s, rx_shift};
`else
    assign rx_entry = {~rx_s, rx_shift};
`endif

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [RX_FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, pop, push_ok;
    logic [EW-1:0] head;

    assign rx_count_o = wr_ptr - rd_ptr;
    assign full       = (rx_count_o == (AW + 1)'(RX_FIFO_DEPTH));
    assign empty      = (rx_count_o == '0);
    assign rx_valid_o = !empty;
    assign pop        = rx_valid_o && rx_ready_i;
    assign push_ok    = rx_push && (!full || pop);
    assign head       = mem[rd_ptr[AW-1:0]];

    // Head outputs are gated so nothing stale shows while the FIFO is empty.
    assign rx_data_o      = empty ? '0 : head[DATA_BITS-1:0];
    assign rx_frame_err_o = !empty && head[DATA_BITS];
`ifdef UART_PARITY_EN
    assign rx_parity_err_o = !empty && head[DATA_BITS+1];
`else
    assign rx_parity_err_o = 1'b0;
`endif

    // FIFO storage write port.
    // NOTE: the storage array has no reset; occupancy is defined by the
    // pointers alone, so clearing the entries would buy nothing.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_entry;
    end

    // FIFO pointers and the overrun pulse for a push that finds no room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_overrun_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW + 1)'(1);
            rx_overrun_o <= rx_push && !push_ok;
        end
    end

endmodule
